// File: rtl/lcg_stim_gen.sv
// LCG stimulus source: packs successive 32-bit LCG draws into a WIDTH-bit vector,
// one draw per cycle, and presents each vector on a valid/ready handshake.
module lcg_stim_gen #(
   parameter int unsigned WIDTH        = 261,
   parameter logic [31:0] DEFAULT_SEED = 32'd1338811290
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             seed_load,
   input  logic [31:0]      seed_in,
   input  logic             start,
   input  logic [31:0]      num_vectors,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_vec,
   output logic [31:0]      vec_idx,
   output logic             busy,
   output logic             done
);

   localparam int unsigned NW    = (WIDTH + 31) / 32;
   localparam int unsigned LastW = WIDTH - 32 * (NW - 1);
   localparam int unsigned KW    = (NW > 1) ? $clog2(NW) : 1;

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StFill  = 2'd1;
   localparam logic [1:0] StValid = 2'd2;
   localparam logic [1:0] StDone  = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [KW-1:0]    k_q, k_d;
   logic [31:0]      lcg_q, lcg_d;
   logic [31:0]      count_q, count_d;
   logic [31:0]      idx_q, idx_d;
   logic [WIDTH-1:0] vec_q, vec_d;
   logic [31:0]      lcg_step;

   // Only the low 32 bits of the product are kept.
   assign lcg_step = lcg_q * 32'h41C64E6D + 32'h0000_3039;

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      lcg_d   = lcg_q;
      count_d = count_q;
      idx_d   = idx_q;
      vec_d   = vec_q;
      case (state_q)
         StIdle, StDone: begin
            if (seed_load) lcg_d = seed_in;
            if (start) begin
               count_d = num_vectors;
               idx_d   = '0;
               k_d     = '0;
               state_d = (num_vectors == '0) ? StDone : StFill;
            end
         end
         StFill: begin
            lcg_d = lcg_step;
            for (int w = 0; w < int'(NW) - 1; w++) begin
               if (k_q == KW'(w)) vec_d[32*w +: 32] = lcg_step;
            end
            // The last word is truncated to the bits that fit in WIDTH.
            if (k_q == KW'(NW - 1)) begin
               vec_d[WIDTH-1 -: LastW] = lcg_step[LastW-1:0];
               state_d = StValid;
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         StValid: begin
            if (out_ready) begin
               if (idx_q + 32'd1 == count_q) begin
                  state_d = StDone;
               end else begin
                  idx_d   = idx_q + 32'd1;
                  k_d     = '0;
                  state_d = StFill;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         k_q     <= '0;
         lcg_q   <= DEFAULT_SEED;
         count_q <= '0;
         idx_q   <= '0;
         vec_q   <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         lcg_q   <= lcg_d;
         count_q <= count_d;
         idx_q   <= idx_d;
         vec_q   <= vec_d;
      end
   end

   assign out_valid = (state_q == StValid);
   assign busy      = (state_q == StFill) || (state_q == StValid);
   assign done      = (state_q == StDone);
   assign out_vec   = vec_q;
   assign vec_idx   = idx_q;

endmodule

// File: tb/tb_lcg_stim_gen.sv
// Directed-sequence bench for lcg_stim_gen with randomized seeds, checked against a
// plain-arithmetic LCG reference model.
module tb_lcg_stim_gen;

   localparam int unsigned WIDTH = 261;
   localparam int unsigned NW    = (WIDTH + 31) / 32;
   localparam logic [31:0] DSEED = 32'd1338811290;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             seed_load = 1'b0;
   logic [31:0]      seed_in = '0;
   logic             start = 1'b0;
   logic [31:0]      num_vectors = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out_vec;
   logic [31:0]      vec_idx;
   logic             busy;
   logic             done;

   int checks = 0;
   int errors = 0;

   logic [31:0]      model_lcg;
   logic [31:0]      model_last;
   logic [WIDTH-1:0] exp_vec;
   logic [WIDTH-1:0] held_vec;
   int               cyc;

   lcg_stim_gen #(.WIDTH(WIDTH), .DEFAULT_SEED(DSEED)) dut (
      .clk(clk), .rst(rst), .seed_load(seed_load), .seed_in(seed_in), .start(start),
      .num_vectors(num_vectors), .out_valid(out_valid), .out_ready(out_ready),
      .out_vec(out_vec), .vec_idx(vec_idx), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                        input logic [WIDTH-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Next vector from the model: NW successive draws, word k at bits [32k+31:32k].
   task automatic model_draw(output logic [WIDTH-1:0] v);
      logic [32*NW-1:0] full;
      full = '0;
      for (int w = 0; w < int'(NW); w++) begin
         model_lcg = model_lcg * 32'h41C64E6D + 32'h0000_3039;
         full[32*w +: 32] = model_lcg;
      end
      model_last = model_lcg;
      v = full[WIDTH-1:0];
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!out_valid && n < 4 * int'(NW));
   endtask

   task automatic begin_run(input logic ld, input logic [31:0] sd, input logic [31:0] n);
      seed_load   = ld;
      seed_in     = sd;
      start       = 1'b1;
      num_vectors = n;
      if (ld) model_lcg = sd;
      tick();
      seed_load = 1'b0;
      start     = 1'b0;
   endtask

   initial begin
      // Reset
      tick();
      tick();
      rst = 1'b0;
      model_lcg = DSEED;
      check("rst_valid", WIDTH'(out_valid), '0);
      check("rst_busy", WIDTH'(busy), '0);
      check("rst_done", WIDTH'(done), '0);
      check("rst_vec", out_vec, '0);
      check("rst_idx", WIDTH'(vec_idx), '0);

      // Seed 0, single vector, ready held high
      out_ready = 1'b1;
      begin_run(1'b1, 32'd0, 32'd1);
      check("t1_busy", WIDTH'(busy), WIDTH'(1));
      check("t1_valid_early", WIDTH'(out_valid), '0);
      wait_valid(cyc);
      model_draw(exp_vec);
      check("t1_latency", WIDTH'(cyc), WIDTH'(NW));
      check("t1_w0", WIDTH'(out_vec[31:0]), WIDTH'(32'h0000_3039));
      check("t1_w1", WIDTH'(out_vec[63:32]), WIDTH'(32'hD3DC_167E));
      check("t1_vec", out_vec, exp_vec);
      tick();
      check("t1_done", WIDTH'(done), WIDTH'(1));
      check("t1_busy_off", WIDTH'(busy), '0);
      check("t1_valid_off", WIDTH'(out_valid), '0);

      // Seed 1, single vector; top bits come from the 9th draw
      begin_run(1'b1, 32'd1, 32'd1);
      check("t2_done_clr", WIDTH'(done), '0);
      wait_valid(cyc);
      model_draw(exp_vec);
      check("t2_w0", WIDTH'(out_vec[31:0]), WIDTH'(32'h41C6_7EA6));
      check("t2_top", WIDTH'(out_vec[260:256]), WIDTH'(model_last[4:0]));
      check("t2_vec", out_vec, exp_vec);
      tick();

      // Three vectors with backpressure on vector 1, random seed
      out_ready = 1'b0;
      begin_run(1'b1, $urandom, 32'd3);
      for (int v = 0; v < 3; v++) begin
         wait_valid(cyc);
         model_draw(exp_vec);
         check($sformatf("t3_lat%0d", v), WIDTH'(cyc), WIDTH'(NW));
         check($sformatf("t3_vec%0d", v), out_vec, exp_vec);
         check($sformatf("t3_idx%0d", v), WIDTH'(vec_idx), WIDTH'(v));
         if (v == 1) begin
            held_vec = exp_vec;
            for (int s = 0; s < 5; s++) begin
               tick();
               check("t3_stall_valid", WIDTH'(out_valid), WIDTH'(1));
               check("t3_stall_vec", out_vec, held_vec);
               check("t3_stall_idx", WIDTH'(vec_idx), WIDTH'(1));
            end
         end
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
         if (v < 2) begin
            check("t3_mid_busy", WIDTH'(busy), WIDTH'(1));
            check("t3_mid_valid", WIDTH'(out_valid), '0);
            check("t3_mid_idx", WIDTH'(vec_idx), WIDTH'(v + 1));
         end
      end
      check("t3_done", WIDTH'(done), WIDTH'(1));
      check("t3_busy_off", WIDTH'(busy), '0);
      check("t3_idx_end", WIDTH'(vec_idx), WIDTH'(2));
      check("t3_vec_hold", out_vec, exp_vec);

      // Zero-length run: immediate done, LCG untouched
      begin_run(1'b0, 32'd0, 32'd0);
      check("t4_done", WIDTH'(done), WIDTH'(1));
      check("t4_busy", WIDTH'(busy), '0);
      check("t4_valid", WIDTH'(out_valid), '0);
      out_ready = 1'b1;
      begin_run(1'b0, 32'd0, 32'd1);
      wait_valid(cyc);
      model_draw(exp_vec);
      check("t4_cont_vec", out_vec, exp_vec);
      tick();

      // Seed load and start pulsed mid-run must be ignored
      out_ready = 1'b0;
      begin_run(1'b0, 32'd0, 32'd2);
      tick();
      tick();
      seed_load = 1'b1; seed_in = $urandom; start = 1'b1; num_vectors = 32'd7;
      tick();
      seed_load = 1'b0; start = 1'b0;
      for (int v = 0; v < 2; v++) begin
         wait_valid(cyc);
         model_draw(exp_vec);
         check($sformatf("t5_vec%0d", v), out_vec, exp_vec);
         seed_load = 1'b1; seed_in = $urandom; start = 1'b1;
         tick();
         seed_load = 1'b0; start = 1'b0;
         check("t5_hold_vec", out_vec, exp_vec);
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
      end
      check("t5_done", WIDTH'(done), WIDTH'(1));

      // Reset during FILL at k=4 aborts; next run restarts from DEFAULT_SEED
      begin_run(1'b1, $urandom, 32'd1);
      for (int i = 0; i < 4; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6_valid", WIDTH'(out_valid), '0);
      check("t6_busy", WIDTH'(busy), '0);
      check("t6_done", WIDTH'(done), '0);
      check("t6_vec", out_vec, '0);
      check("t6_idx", WIDTH'(vec_idx), '0);
      model_lcg = DSEED;
      begin_run(1'b0, 32'd0, 32'd1);
      wait_valid(cyc);
      model_draw(exp_vec);
      check("t6_latency", WIDTH'(cyc), WIDTH'(NW));
      check("t6_first_vec", out_vec, exp_vec);
      out_ready = 1'b1;
      tick();
      check("t6_done_end", WIDTH'(done), WIDTH'(1));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lcg_stim_gen.md
# lcg_stim_gen

Synthesizable stimulus source for the fuzz harness. It reproduces the testbench linear-congruential sequence in hardware and packs successive 32-bit draws into a WIDTH-bit input vector. It sits directly upstream of the design under test and drives its `in_flat` bus. A valid/ready handshake lets a downstream capture or compare stage apply backpressure.

## Interface
Parameters:
- `WIDTH`, 261: output vector width; words per vector `NW = ceil(WIDTH/32)` (9 at default).
- `DEFAULT_SEED`, 32'd1338811290: LCG state loaded at reset.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `seed_load`  in  1  load `seed_in` into LCG state (IDLE/DONE only).
- `seed_in`  in  32  new seed.
- `start`  in  1  begin a run of `num_vectors` vectors (IDLE/DONE only).
- `num_vectors`  in  32  vectors in the run, sampled with `start`.
- `out_valid`  out  1  `out_vec` holds a complete vector.
- `out_ready`  in  1  downstream accepts the vector.
- `out_vec`  out  WIDTH  packed stimulus vector.
- `vec_idx`  out  32  index of the current or next vector in the run, from 0.
- `busy`  out  1  high in FILL or VALID.
- `done`  out  1  run complete, held until the next `start` or `rst`.

## Operation
- LCG step: `state <= state*32'h41C64E6D + 32'h3039`, mod 2^32. Use the low 32 bits of the product only.
- Packing: step k (0..NW-1) writes the new state to `out_vec[32k+31:32k]`. The last word writes only its low `WIDTH-32*(NW-1)` bits (bits [4:0] at default).
- States:
  - IDLE: entered from reset.
  - FILL: counter `k`.
  - VALID
  - DONE
- Transitions:
  - IDLE/DONE, `start=1`:
    - Latch `num_vectors` and clear `vec_idx`.
    - If `num_vectors==0`, go to DONE.
    - Otherwise go to FILL with `k=0`; `done` clears.
  - FILL: one LCG step per cycle. Go to VALID after the step with `k==NW-1`.
  - VALID, `out_ready=1`:
    - If `vec_idx+1 == count`, go to DONE.
    - Otherwise increment `vec_idx` and go to FILL with `k=0`.
  - VALID, `out_ready=0`: hold. `out_vec` and `vec_idx` stay stable.
- Seed handling:
  - `seed_load` in IDLE/DONE replaces the state.
  - `seed_load` together with `start` on the same edge: the first step of the run uses `seed_in`.
  - `seed_load` while `busy` is ignored.
- LCG state persists across runs. A new `start` without `seed_load` continues the sequence.
- `start` while `busy` is ignored.
- `out_vec` changes only in FILL. It is stable in VALID, DONE and IDLE.
- Reset values:
  - `out_valid=0`, `busy=0`, `done=0`
  - `out_vec=0`, `vec_idx=0`
  - state=IDLE, LCG state=`DEFAULT_SEED`

## Timing
- Start latency: `start` sampled at edge E0 puts the block in FILL. `out_valid` rises after edge E0+NW, so it is first high NW cycles after E0.
- Per-vector cost: a handshake at edge H returns the block to FILL; the next `out_valid` is high after H+NW. Peak throughput is one vector per NW+1 cycles.
- `out_valid` is a registered state decode. It never depends combinationally on `out_ready`.
- `done` rises on the same edge that accepts the final vector. For `num_vectors==0` it rises on the `start` edge.
- `busy = (state==FILL) || (state==VALID)`, registered.
- Reset mid-FILL or mid-VALID aborts the run. The next cycle shows all reset values and the LCG state is `DEFAULT_SEED`. A partially accepted vector is not re-presented.
- `vec_idx` wraps modulo 2^32 (unreachable in practice); no saturation.

## Test plan
- Reset, then `seed_load=1`, `seed_in=0`, `start=1`, `num_vectors=1`, `out_ready=1` on the same edge -> `out_valid` high 9 cycles later with `out_vec[31:0]=32'h00003039` and `out_vec[63:32]=32'hD3DC167E`. `done=1` follows the handshake edge.
- `seed_in=1`, one vector -> `out_vec[31:0]=32'h41C67EA6`. Bits [260:256] equal the low 5 bits of the 9th state.
- `num_vectors=3`, `out_ready` low for 5 cycles on vector 1 -> `out_vec` and `vec_idx=1` stable while stalled. Exactly 3 handshakes occur, `vec_idx` runs 0,1,2, and `busy` falls with `done`.
- `num_vectors=0` -> `done=1` one edge after `start`. `out_valid` stays 0 and the LCG state is unchanged.
- `seed_load` and `start` pulsed mid-run -> both ignored. The run and sequence match the reference model.
- `rst` asserted at FILL `k=4` -> all outputs reset next cycle. A new run from `DEFAULT_SEED` reproduces the testbench's first vector bit-exactly.
